// File: rtl/cma_coeff_bank.sv
// cma_coeff_bank: FFE coefficient store with gated CMA commits; define CMA_COEFF_SAT_GUARD_EN to clamp -2^(NB-1) taps
module cma_coeff_bank #(
  parameter int FFE_LEN       = 21,
  parameter int NB            = 8,
  parameter int NBF           = 7,
  parameter int CENTER_TAP    = 10,
  parameter int INIT_CENTER   = 1 << (NBF - 1),
  parameter int STARTUP_DELAY = 63,
  parameter int UPDATE_DIV    = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_enable,
  input  logic                  i_freeze,
  input  logic                  i_clear,
  input  logic [FFE_LEN*NB-1:0] i_new_coeff,
  output logic [FFE_LEN*NB-1:0] o_coeff,
  output logic                  o_update,
  output logic [1:0]            o_state,
  output logic                  o_sat_flag
);
  localparam int W  = FFE_LEN * NB;
  localparam int WW = STARTUP_DELAY > 0 ? $clog2(STARTUP_DELAY + 1) : 1;
  localparam int DW = UPDATE_DIV > 1 ? $clog2(UPDATE_DIV) : 1;
  localparam logic [W-1:0] INIT = W'($unsigned(NB'(INIT_CENTER))) << (CENTER_TAP * NB);
  typedef enum logic [1:0] {IDLE = 2'b00, WARMUP = 2'b01, ADAPT = 2'b10} state_t;
  state_t state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [W-1:0] coeff, coeff_n, wr_coeff;
  logic upd, upd_n, sat, sat_n, wr_sat, last;
`ifdef CMA_COEFF_SAT_GUARD_EN
  logic [FFE_LEN-1:0] hit;
  for (genvar k = 0; k < FFE_LEN; k++) begin : g_clamp
    assign hit[k] = i_new_coeff[k*NB +: NB] == {1'b1, {(NB-1){1'b0}}};
    assign wr_coeff[k*NB +: NB] = hit[k] ? {1'b1, {(NB-2){1'b0}}, 1'b1} : i_new_coeff[k*NB +: NB];
  end
  assign wr_sat = |hit;
`else
  assign wr_coeff = i_new_coeff;
  assign wr_sat = 1'b0;
`endif
  assign last = dcnt == DW'(UPDATE_DIV - 1);
  always_comb begin
    state_n = state;
    wcnt_n = wcnt;
    dcnt_n = dcnt;
    coeff_n = coeff;
    upd_n = 1'b0;
    sat_n = sat;
    if (i_clear) begin
      state_n = IDLE;
      wcnt_n = '0;
      dcnt_n = '0;
      coeff_n = INIT;
      sat_n = 1'b0;
    end else if (!i_enable) begin
      state_n = IDLE;
      wcnt_n = '0;
      dcnt_n = '0;
    end else begin
      case (state)
        IDLE: state_n = WARMUP;
        WARMUP: begin
          if (STARTUP_DELAY == 0 || (i_valid && wcnt == WW'(STARTUP_DELAY - 1))) begin
            state_n = ADAPT;
            wcnt_n = '0;
            dcnt_n = '0;
          end else if (i_valid) wcnt_n = wcnt + 1'b1;
        end
        ADAPT: begin
          if (i_valid) begin
            dcnt_n = last ? '0 : dcnt + 1'b1;
            if (last && !i_freeze) begin
              coeff_n = wr_coeff;
              upd_n = 1'b1;
              sat_n = sat | wr_sat;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      wcnt <= '0;
      dcnt <= '0;
      coeff <= INIT;
      upd <= 1'b0;
      sat <= 1'b0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      dcnt <= dcnt_n;
      coeff <= coeff_n;
      upd <= upd_n;
      sat <= sat_n;
    end
  end
  assign o_coeff = coeff;
  assign o_update = upd;
  assign o_state = state;
  assign o_sat_flag = sat;
endmodule

// File: doc/cma_coeff_bank.md
Name: cma_coeff_bank

Overview:
- Coefficient store and adaptation controller for the FFE.
- Holds the FFE_LEN-tap coefficient vector that feeds the filter and the CMA tap updater.
- Accepts the updater's proposed new coefficient vector and commits it only after a startup delay, once every UPDATE_DIV valid samples, and only while adaptation is enabled and not frozen.
- Sits between the CMA updater's output and the FFE coefficient input, closing the adaptation loop.

Parameters:
- FFE_LEN, 21, number of taps.
- NB, 8, coefficient width (signed).
- NBF, 7, coefficient fractional bits.
- CENTER_TAP, 10, index of the tap initialised non-zero; index FFE_LEN-1 is the newest sample.
- INIT_CENTER, 64, reset/clear value of the center tap (0.5 at NBF=7); all other taps reset to 0.
- STARTUP_DELAY, 63, valid samples to wait before the first commit (3*FFE_LEN).
- UPDATE_DIV, 4, commit one update every UPDATE_DIV valid samples. Must be ≥1.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  sample strobe; all counting advances only on i_valid=1.
- i_enable  in  1  adaptation enable (level).
- i_freeze  in  1  suppresses commits without stopping counters.
- i_clear  in  1  synchronous pulse: reload init coefficients, return to IDLE.
- i_new_coeff  in  FFE_LEN*NB  proposed coefficients; tap k at [k*NB +: NB].
- o_coeff  out  FFE_LEN*NB  current committed coefficients, same packing.
- o_update  out  1  one-cycle pulse, high the cycle o_coeff changes from a commit.
- o_state  out  2  00 IDLE, 01 WARMUP, 10 ADAPT.
- o_sat_flag  out  1  sticky clamp indicator (see Optional Feature).

Behaviour:
- Reset (async, active-high) values:
  - o_coeff: tap CENTER_TAP = INIT_CENTER, all other taps 0.
  - o_update = 0, o_state = IDLE, o_sat_flag = 0.
  - Warm-up counter and decimation counter = 0.
- Counters:
  - Warm-up counter width is clog2(STARTUP_DELAY+1).
  - Decimation counter width is clog2(UPDATE_DIV), minimum 1 bit.
- Priority per cycle: i_clear > i_enable=0 > normal FSM.
  - i_clear=1 applies the reset values of o_coeff, counters and o_sat_flag, sets o_state=IDLE and forces o_update=0, regardless of any other input.
- IDLE:
  - Coefficients hold; counters held at 0.
  - i_enable=1 -> WARMUP next cycle.
- WARMUP:
  - Each i_valid increments the warm-up counter.
  - On the i_valid that brings the count to STARTUP_DELAY -> ADAPT, with the decimation counter at 0.
  - STARTUP_DELAY=0 -> go straight to ADAPT on the first cycle in WARMUP.
  - No commits occur in WARMUP.
- ADAPT:
  - Each i_valid increments the decimation counter, wrapping UPDATE_DIV-1 -> 0.
  - Commit condition: i_valid=1, counter==UPDATE_DIV-1, and i_freeze=0.
  - On commit, i_new_coeff is registered into o_coeff on that clock edge, so it is visible the next cycle.
  - o_update pulses for exactly that one following cycle.
  - i_freeze=1 blocks the write and the pulse; the counter still wraps.
  - UPDATE_DIV=1 -> commit on every valid sample.
- Enable deassertion:
  - i_enable=0 in WARMUP or ADAPT -> IDLE next cycle; counters clear; coefficients are retained, not reinitialised.
  - A commit coinciding with i_enable=0 is dropped.
  - Re-enabling repeats the full warm-up.
- i_valid=0: no counter advance and no commit, in any state.
- o_coeff is purely registered. There is no combinational path from i_new_coeff to o_coeff.

Optional Feature:
- Macro: CMA_COEFF_SAT_GUARD_EN.
- Defined:
  - Each committed tap equal to -2^(NB-1) (-128) is written as -(2^(NB-1)-1) (-127), keeping the coefficient range symmetric.
  - o_sat_flag sets on any commit where a clamp occurred.
  - o_sat_flag stays set until reset or i_clear.
- Undefined:
  - Taps are written verbatim.
  - o_sat_flag is tied to 0.

Test Plan:
- Reset then idle: assert i_reset async mid-cycle -> o_coeff tap10=64, others 0, o_state=00, o_update=0; no change with i_valid toggling while i_enable=0.
- Warm-up timing: i_enable=1, i_valid every cycle, i_new_coeff all taps=5 -> o_state=01 for 63 valid samples, then 10; first o_update after valid #4 in ADAPT; o_coeff all 5 the following cycle; pulses every 4th valid thereafter.
- Sparse valid and freeze: in ADAPT, i_valid every 3rd cycle -> commit every 12 cycles. Hold i_freeze=1 across two commit slots -> no o_update, o_coeff unchanged. Release freeze -> the next slot commits, with slot phase preserved.
- Disable/re-enable: drop i_enable on a commit slot -> no commit, o_state=00, coefficients retained. Re-enable -> full 63-sample warm-up again.
- Clear priority: i_clear=1 on the same cycle as a commit slot with i_new_coeff all -3 -> o_coeff returns to init, o_state=00, no o_update.
- With CMA_COEFF_SAT_GUARD_EN: commit tap 0 = -128 -> o_coeff tap0=-127, o_sat_flag=1 and sticky until i_clear. Without the macro: tap0=-128, o_sat_flag=0.
